// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: latch enables/flushes, PC enable, EX forwarding, halt-drain FSM, perf counters.
// Optional feature macro: HZU_FWD_EN (EX-stage forwarding; otherwise every RAW hazard stalls).
module hazard_ctrl_unit #(
    parameter int REGW      = 5,
    parameter int DRAIN_CYC = 3,
    parameter int CNTW      = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ihit,
    input  logic            dmem_req,
    input  logic            dhit,
    input  logic            halt_id,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic [REGW-1:0] ifid_rs,
    input  logic [REGW-1:0] ifid_rt,
    input  logic [REGW-1:0] idex_rs,
    input  logic [REGW-1:0] idex_rt,
    input  logic [REGW-1:0] idex_rd,
    input  logic            idex_wen,
    input  logic            idex_load,
    input  logic [REGW-1:0] exmem_rd,
    input  logic            exmem_wen,
    input  logic [REGW-1:0] memwb_rd,
    input  logic            memwb_wen,
    output logic            pc_en,
    output logic            en_ifid,
    output logic            en_idex,
    output logic            en_exmem,
    output logic            en_memwb,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            flush_memwb,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            halted,
    output logic [CNTW-1:0] cnt_dstall,
    output logic [CNTW-1:0] cnt_istall,
    output logic [CNTW-1:0] cnt_flush
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam int DCW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC);

    state_t          state, state_nxt;
    logic [DCW-1:0]  dcnt, dcnt_nxt;
    logic            redir_pend, redir_pend_nxt;
    logic            dmiss, redir, lduse, imiss;
    logic            inc_d, inc_i, inc_f;
    logic            pc_en_c, en_ifid_c, en_idex_c, en_exmem_c, en_memwb_c;
    logic            flush_ifid_c, flush_idex_c, flush_memwb_c;

    function automatic logic writes_src(input logic wen, input logic [REGW-1:0] rd,
                                        input logic [REGW-1:0] rs, input logic [REGW-1:0] rt);
        return wen && (rd != '0) && ((rd == rs) || (rd == rt));
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v, input logic inc);
        if (inc && (v != {CNTW{1'b1}}))
            return v + CNTW'(1);
        return v;
    endfunction

`ifdef HZU_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src);
        if (exmem_wen && (exmem_rd != '0) && (exmem_rd == src))
            return 2'b01;
        if (memwb_wen && (memwb_rd != '0) && (memwb_rd == src))
            return 2'b10;
        return 2'b00;
    endfunction

    assign lduse = idex_load && writes_src(idex_wen, idex_rd, ifid_rs, ifid_rt);
    assign fwd_a = RST ? 2'b00 : fwd_sel(idex_rs);
    assign fwd_b = RST ? 2'b00 : fwd_sel(idex_rt);
`else
    // Without forwarding, any in-flight writer of an ID source holds ID until it retires.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{idex_rs, idex_rt, idex_load};
    assign lduse = writes_src(idex_wen, idex_rd, ifid_rs, ifid_rt)
                 | writes_src(exmem_wen, exmem_rd, ifid_rs, ifid_rt)
                 | writes_src(memwb_wen, memwb_rd, ifid_rs, ifid_rt);
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    assign dmiss = dmem_req & ~dhit;
    assign redir = branch_taken | jump | redir_pend;
    assign imiss = ~ihit;

    always_comb begin
        pc_en_c        = 1'b1;
        en_ifid_c      = 1'b1;
        en_idex_c      = 1'b1;
        en_exmem_c     = 1'b1;
        en_memwb_c     = 1'b1;
        flush_ifid_c   = 1'b0;
        flush_idex_c   = 1'b0;
        flush_memwb_c  = 1'b0;
        state_nxt      = state;
        dcnt_nxt       = dcnt;
        redir_pend_nxt = redir_pend;
        inc_d          = 1'b0;
        inc_i          = 1'b0;
        inc_f          = 1'b0;

        if (state == HALTED) begin
            pc_en_c    = 1'b0;
            en_ifid_c  = 1'b0;
            en_idex_c  = 1'b0;
            en_exmem_c = 1'b0;
            en_memwb_c = 1'b0;
        end else if (dmiss) begin
            pc_en_c       = 1'b0;
            en_ifid_c     = 1'b0;
            en_idex_c     = 1'b0;
            en_exmem_c    = 1'b0;
            en_memwb_c    = 1'b0;
            flush_memwb_c = 1'b1;
            inc_d         = 1'b1;
            // EX redirect seen while frozen must survive until the miss resolves.
            if (branch_taken || jump)
                redir_pend_nxt = 1'b1;
        end else if (redir) begin
            flush_ifid_c   = 1'b1;
            flush_idex_c   = 1'b1;
            inc_f          = 1'b1;
            redir_pend_nxt = 1'b0;
            if (state == DRAIN) begin
                state_nxt = RUN;
                dcnt_nxt  = '0;
            end
        end else if (state == DRAIN) begin
            pc_en_c      = 1'b0;
            flush_ifid_c = 1'b1;
            dcnt_nxt     = dcnt + DCW'(1);
            if (dcnt_nxt == DRAIN_LAST)
                state_nxt = HALTED;
        end else begin
            if (lduse) begin
                pc_en_c      = 1'b0;
                en_ifid_c    = 1'b0;
                flush_idex_c = 1'b1;
            end else if (imiss) begin
                pc_en_c      = 1'b0;
                flush_ifid_c = 1'b1;
                inc_i        = 1'b1;
            end
            // Halt commits to draining only once it actually moves into EX.
            if (halt_id && !lduse) begin
                state_nxt = DRAIN;
                dcnt_nxt  = '0;
            end
        end
    end

    assign pc_en       = pc_en_c & ~RST;
    assign en_ifid     = en_ifid_c & ~RST;
    assign en_idex     = en_idex_c & ~RST;
    assign en_exmem    = en_exmem_c & ~RST;
    assign en_memwb    = en_memwb_c & ~RST;
    assign flush_ifid  = flush_ifid_c | RST;
    assign flush_idex  = flush_idex_c | RST;
    assign flush_memwb = flush_memwb_c | RST;
    assign halted      = (state == HALTED);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= RUN;
            dcnt       <= '0;
            redir_pend <= 1'b0;
            cnt_dstall <= '0;
            cnt_istall <= '0;
            cnt_flush  <= '0;
        end else begin
            state      <= state_nxt;
            dcnt       <= dcnt_nxt;
            redir_pend <= redir_pend_nxt;
            cnt_dstall <= sat_inc(cnt_dstall, inc_d);
            cnt_istall <= sat_inc(cnt_istall, inc_i);
            cnt_flush  <= sat_inc(cnt_flush, inc_f);
        end
    end

endmodule
